// File: rtl/cdc_hs_tx_ctrl.sv
// cdc_hs_tx_ctrl
// Source-side four-phase req/ack handshake controller. It accepts a word on
// a valid/ready port, freezes it on x_data and runs req/ack with a receiver
// in an unrelated clock domain. x_ack is brought in through a SYNC_STAGES
// flop synchronizer. An optional timeout abandons a REQ phase whose ack
// never arrives and raises a sticky error flag.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   s_valid      source word valid
//   s_ready      controller can accept a word (registered)
//   s_data       source word
//   x_req        handshake request to remote domain (registered)
//   x_data       held word, stable whenever x_req=1 (registered)
//   x_ack        asynchronous acknowledge from remote domain
//   busy         handshake in progress, state != IDLE (registered)
//   timeout_err  sticky abandoned-handshake flag (registered)
//   err_clr      synchronous clear of timeout_err
module cdc_hs_tx_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             x_req,
  output logic [WIDTH-1:0] x_data,
  input  logic             x_ack,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);

  // Counter keeps at least one bit so a disabled timeout still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [SYNC_STAGES-1:0]  ack_sync;
  logic                    ack_s;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    s_ready_d;
  logic                    x_req_d;
  logic [WIDTH-1:0]        x_data_d;
  logic                    busy_d;
  logic                    err_d;
  logic                    err_set;

  // Ack synchronizer; the FSM only ever looks at the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], x_ack};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_ready     <= 1'b0;
      x_req       <= 1'b0;
      x_data      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_ready     <= s_ready_d;
      x_req       <= x_req_d;
      x_data      <= x_data_d;
      busy        <= busy_d;
      timeout_err <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_ready_d = s_ready;
    x_req_d   = x_req;
    x_data_d  = x_data;
    err_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        s_ready_d = 1'b1;
        x_req_d   = 1'b0;
        // s_ready is the registered flag, so nothing is taken on the
        // first edge after reset release.
        if (s_valid && s_ready) begin
          x_data_d  = s_data;
          x_req_d   = 1'b1;
          s_ready_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        s_ready_d = 1'b0;
        x_req_d   = 1'b1;
        // A real ack always beats a coincident timeout.
        if (ack_s) begin
          x_req_d = 1'b0;
          state_d = ST_REL;
        end else if (TIMEOUT_CYC != 0) begin
          if (cnt_q == CNT_LAST) begin
            x_req_d = 1'b0;
            err_set = 1'b1;
            state_d = ST_REL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_REL: begin
        s_ready_d = 1'b0;
        x_req_d   = 1'b0;
        // Wait for the remote side to drop ack before taking a new word.
        if (!ack_s) begin
          s_ready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        s_ready_d = 1'b0;
        x_req_d   = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // Setting the sticky flag takes priority over a coincident clear.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = timeout_err;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Bench for cdc_hs_tx_ctrl. Main instance (TIMEOUT_CYC=255) covers reset,
// loopback, back-to-back, slow remote and mid-handshake reset; a second
// instance (TIMEOUT_CYC=16, ack tied low) covers the timeout flag.
// Words are pushed to a scoreboard when driven and popped when x_req rises.
module tb_cdc_hs_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       x_req;
  logic [7:0] x_data;
  logic       x_ack;
  logic       busy;
  logic       timeout_err;
  logic       err_clr = 1'b0;
  logic       loop_en = 1'b0;
  logic       ack_drv = 1'b0;

  logic       t_s_valid = 1'b0;
  logic       t_s_ready;
  logic [7:0] t_s_data = 8'h00;
  logic       t_x_req;
  logic [7:0] t_x_data;
  logic       t_x_ack = 1'b0;
  logic       t_busy;
  logic       t_err;
  logic       t_err_clr = 1'b0;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         rise_q[$];
  logic       prev_req = 1'b0;
  logic [7:0] held = 8'h00;

  assign x_ack = loop_en ? x_req : ack_drv;

  always #5 clk = ~clk;

  cdc_hs_tx_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYC(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .x_req(x_req), .x_data(x_data), .x_ack(x_ack),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  cdc_hs_tx_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .s_valid(t_s_valid), .s_ready(t_s_ready),
    .s_data(t_s_data), .x_req(t_x_req), .x_data(t_x_data), .x_ack(t_x_ack),
    .busy(t_busy), .timeout_err(t_err), .err_clr(t_err_clr)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(s_ready && !busy) && n < 60) begin
      tick();
      n++;
    end
    chk_eq(tag, 32'(s_ready & ~busy), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop on each x_req rise; x_data must not move while x_req=1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (x_req && !prev_req) begin
        rise_q.push_back(cyc);
        chk_eq("sb_depth_on_rise", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk_eq("sb_word", x_data, sb.pop_front());
        held <= x_data;
      end else if (x_req && prev_req) begin
        chk_eq("x_data_hold", x_data, held);
      end
    end
    prev_req <= x_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int idx;
    logic last_x;

    // Reset with s_valid held high.
    s_valid = 1'b1;
    s_data  = 8'hFF;
    #2 rst_n = 1'b0;
    tick(3);
    chk_eq("rst_s_ready", s_ready, 0);
    chk_eq("rst_x_req", x_req, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_err", timeout_err, 0);
    chk_eq("rst_x_data", x_data, 0);
    chk_eq("rst_t_s_ready", t_s_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_eq("post_rst_s_ready", s_ready, 1);
    chk_eq("post_rst_no_accept_req", x_req, 0);
    chk_eq("post_rst_no_accept_busy", busy, 0);
    chk_eq("post_rst_x_data", x_data, 0);
    s_valid = 1'b0;
    tick();

    // Single loopback transfer of 0xA5.
    loop_en = 1'b1;
    s_data  = 8'hA5;
    s_valid = 1'b1;
    sb.push_back(8'hA5);
    tick();
    s_valid = 1'b0;
    chk_eq("single_e0_x_req", x_req, 1);
    chk_eq("single_e0_busy", busy, 1);
    chk_eq("single_e0_s_ready", s_ready, 0);
    chk_eq("single_e0_x_data", x_data, 8'hA5);
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk_eq($sformatf("single_e%0d_x_req", e), x_req, (e <= 2) ? 1 : 0);
      chk_eq($sformatf("single_e%0d_busy", e), busy, (e <= 5) ? 1 : 0);
      chk_eq($sformatf("single_e%0d_s_ready", e), s_ready, (e <= 5) ? 0 : 1);
    end
    chk_eq("single_x_data_held", x_data, 8'hA5);

    // Back-to-back loopback with s_valid held high.
    rise_q.delete();
    base = cyc + 1;
    s_data  = 8'h11;
    s_valid = 1'b1;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    idx = 0;
    last_x = 1'b0;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      tick();
      if (x_req && !last_x) begin
        idx++;
        if (idx == 1) s_data = 8'h22;
        else if (idx == 2) s_data = 8'h33;
        else s_valid = 1'b0;
      end
      last_x = x_req;
    end
    chk_eq("b2b_accepts", idx, 3);
    wait_idle("b2b_idle");
    chk_eq("b2b_rise_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk_eq("b2b_first_edge", rise_q[0] - base, 0);
      chk_eq("b2b_period_1", rise_q[1] - rise_q[0], 7);
      chk_eq("b2b_period_2", rise_q[2] - rise_q[1], 7);
    end
    chk_eq("b2b_sb_drain", sb.size(), 0);
    chk_eq("b2b_x_data_last", x_data, 8'h33);

    // Slow remote: ack rises 20 cycles after x_req.
    loop_en = 1'b0;
    ack_drv = 1'b0;
    tick();
    s_data  = 8'h3C;
    s_valid = 1'b1;
    sb.push_back(8'h3C);
    tick();
    s_valid = 1'b0;
    chk_eq("slow_e0_x_req", x_req, 1);
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk_eq($sformatf("slow_e%0d_x_req", e), x_req, 1);
    end
    ack_drv = 1'b1;
    for (int e = 21; e <= 25; e++) begin
      tick();
      chk_eq($sformatf("slow_e%0d_x_req", e), x_req, (e <= 22) ? 1 : 0);
      chk_eq($sformatf("slow_e%0d_busy", e), busy, 1);
    end
    ack_drv = 1'b0;
    for (int e = 26; e <= 28; e++) begin
      tick();
      chk_eq($sformatf("slow_e%0d_busy", e), busy, (e <= 27) ? 1 : 0);
      chk_eq($sformatf("slow_e%0d_s_ready", e), s_ready, (e <= 27) ? 0 : 1);
    end
    chk_eq("slow_no_err", timeout_err, 0);
    chk_eq("slow_x_data", x_data, 8'h3C);

    // Timeout instance, ack tied low.
    t_s_data  = 8'h77;
    t_s_valid = 1'b1;
    tick();
    t_s_valid = 1'b0;
    chk_eq("to_e0_x_req", t_x_req, 1);
    chk_eq("to_e0_x_data", t_x_data, 8'h77);
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk_eq($sformatf("to_e%0d_x_req", e), t_x_req, 1);
      chk_eq($sformatf("to_e%0d_err", e), t_err, 0);
    end
    tick();
    chk_eq("to_e16_x_req", t_x_req, 0);
    chk_eq("to_e16_err", t_err, 1);
    chk_eq("to_e16_busy", t_busy, 1);
    tick();
    chk_eq("to_e17_s_ready", t_s_ready, 1);
    chk_eq("to_e17_busy", t_busy, 0);
    chk_eq("to_e17_err_sticky", t_err, 1);
    t_err_clr = 1'b1;
    tick();
    t_err_clr = 1'b0;
    chk_eq("to_clr", t_err, 0);

    // Timeout coinciding with err_clr: the set wins.
    t_s_data  = 8'h78;
    t_s_valid = 1'b1;
    tick();
    t_s_valid = 1'b0;
    tick(15);
    chk_eq("to2_e15_err", t_err, 0);
    t_err_clr = 1'b1;
    tick();
    t_err_clr = 1'b0;
    chk_eq("to2_set_wins", t_err, 1);
    chk_eq("to2_x_req", t_x_req, 0);
    tick();
    chk_eq("to2_idle", t_s_ready, 1);

    // Reset in the middle of REQ, then a clean transfer.
    s_data  = 8'h99;
    s_valid = 1'b1;
    sb.push_back(8'h99);
    tick();
    s_valid = 1'b0;
    chk_eq("mid_x_req", x_req, 1);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_x_req", x_req, 0);
    chk_eq("mid_rst_busy", busy, 0);
    chk_eq("mid_rst_s_ready", s_ready, 0);
    chk_eq("mid_rst_x_data", x_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_eq("mid_post_s_ready", s_ready, 1);
    loop_en = 1'b1;
    s_data  = 8'h5A;
    s_valid = 1'b1;
    sb.push_back(8'h5A);
    tick();
    s_valid = 1'b0;
    chk_eq("mid_new_x_req", x_req, 1);
    chk_eq("mid_new_x_data", x_data, 8'h5A);
    wait_idle("mid_new_idle");
    chk_eq("mid_new_no_err", timeout_err, 0);
    chk_eq("mid_new_x_data_held", x_data, 8'h5A);
    chk_eq("final_sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx_ctrl.md
# cdc_hs_tx_ctrl

Source-side four-phase req/ack handshake controller for passing a WIDTH-bit word into an unrelated clock domain. It accepts a word on a valid/ready port, freezes it on x_data, and runs the req/ack sequence with the remote receiver. The asynchronous x_ack input passes through an internal SYNC_STAGES flop synchronizer. An optional timeout abandons a handshake whose ack never arrives.

## Interface
- WIDTH, 8: data word width.
- SYNC_STAGES, 2: flops in the ack synchronizer. Must be ≥2.
- TIMEOUT_CYC, 255: REQ-state cycle limit. 0 disables the timeout. Counter width is $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  source word valid.
- s_ready  out  1  controller can accept a word.
- s_data  in  WIDTH  source word.
- x_req  out  1  handshake request to the remote domain. Registered, glitch-free.
- x_data  out  WIDTH  held word, stable whenever x_req=1.
- x_ack  in  1  asynchronous acknowledge from the remote domain.
- busy  out  1  handshake in progress (state≠IDLE).
- timeout_err  out  1  sticky flag: a handshake was abandoned.
- err_clr  in  1  synchronous clear of timeout_err.

## Operation
- Internal ack_s is x_ack delayed through SYNC_STAGES flops, all cleared on reset. The FSM uses only ack_s, never x_ack directly.
- IDLE:
  - s_ready=1, x_req=0.
  - s_valid&s_ready at an edge → x_data<=s_data, x_req<=1, timeout counter<=0, go to REQ.
- REQ:
  - x_req=1, s_ready=0.
  - ack_s=1 → x_req<=0, go to REL.
  - Else, if TIMEOUT_CYC≠0, the counter increments. At the TIMEOUT_CYC-th REQ edge with ack_s=0: x_req<=0, timeout_err<=1, go to REL.
  - ack_s=1 on the same edge as the timeout → normal path, no error.
- REL:
  - x_req=0, s_ready=0.
  - ack_s=0 → go to IDLE, s_ready<=1.
  - No timeout in REL.
- x_data changes only on an accept edge and holds its value through REQ, REL and IDLE.
- timeout_err:
  - err_clr=1 clears it on the next edge.
  - A timeout and err_clr on the same edge → the set wins.
- s_valid while s_ready=0 is ignored. s_data is not sampled.
- Outputs s_ready, x_req, busy and timeout_err are all registered.

## Timing
- Reset (async, immediate) forces:
  - s_ready=0, x_req=0, busy=0, timeout_err=0, x_data=0.
  - state IDLE, sync flops 0.
- s_ready rises at the first clk edge after rst_n deasserts.
- Reset mid-handshake: x_req drops immediately and the in-flight word is lost. The remote domain must be reset alongside.
- Accept at edge 0:
  - x_req=1 and busy=1 after edge 0. s_ready=0 after edge 0.
  - With x_ack rising at time t, ack_s rises after the SYNC_STAGES-th edge following t.
- Loopback (x_ack=x_req, zero delay), SYNC_STAGES=S:
  - x_req falls after edge S+1.
  - FSM returns to IDLE at edge 2S+2; s_ready=1 after that edge.
  - Next accept at edge 2S+3. The period is 2S+3 cycles (7 for S=2).
- Throughput is at most one word per period. No buffering beyond x_data.

## Test plan
- Reset check: hold rst_n=0 and drive s_valid=1 → all outputs 0 during reset. s_ready=1 after the first edge post-release, and no accept occurs while s_ready=0.
- Single loopback transfer, S=2: s_data=0xA5 accepted at edge 0 → x_data=0xA5, x_req high for edges 1–3, busy low after edge 6, s_ready=1 after edge 6.
- Back-to-back loopback, s_valid held: words 0x11, 0x22, 0x33 → accepts at edges 0, 7, 14. x_data never changes while x_req=1.
- Slow remote, x_ack rising 20 cycles after x_req → x_req stays high until 3 edges after the ack rise (2-flop sync plus FSM edge), then completes with no error.
- Timeout, TIMEOUT_CYC=16, x_ack tied 0 → x_req falls and timeout_err=1 after the 16th REQ edge. IDLE is reached on the next edge. err_clr=1 then clears the flag. A timeout with err_clr asserted on the same edge leaves the flag at 1.
- Reset mid-REQ: assert rst_n=0 while x_req=1 → x_req and busy drop with no clk edge. After release, a new word (0x5A) completes normally.
